// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// legal range of the operand width.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    function automatic bit width_ok(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Load/result handshake of the bit-serial adder: start/busy/done plus
// operands and the held result.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder_full_adder.sv
// Single-bit combinational full adder cell reused by the serial adder.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell, one LSB pair per clock,
// carry held in a register between cycles; result valid with a done pulse.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("serial_adder: WIDTH must lie in 2..32");
    end

    state_t           r_state;
    state_t           w_next;
    logic             w_load;
    logic             w_shift;
    logic             w_last;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_fa_sum;
    logic             w_fa_cout;
    logic [WIDTH-1:0] w_acc_next;

    full_adder u_fa (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_cin  (r_carry),
        .o_sum  (w_fa_sum),
        .o_cout (w_fa_cout)
    );

    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_acc_next = {w_fa_sum, r_acc[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Start is only honoured in IDLE and DONE; SHIFT ignores it entirely.
    always_comb begin
        w_next  = r_state;
        w_load  = 1'b0;
        w_shift = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_load = 1'b1;
                    w_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_shift = 1'b1;
                if (w_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    w_load = 1'b1;
                    w_next = ST_SHIFT;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else if (w_load) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.cin;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (w_shift) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_acc   <= w_acc_next;
            r_carry <= w_fa_cout;
            r_cnt   <= r_cnt + CNT_W'(1);
            // Outputs only see the finished word, never partial bits.
            if (w_last) begin
                r_sum  <= w_acc_next;
                r_cout <= w_fa_cout;
            end
        end
    end

    assign bus.busy = (r_state == ST_SHIFT);
    assign bus.done = (r_state == ST_DONE);
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;

endmodule
